// File: rtl/signal_switch_if.sv
// Sample-stream bundle for signal_switch: channel-swap request, the two
// input streams, the two registered output streams and the effective
// selection. The master side drives switch/a/b; the slave side (the switch
// itself) drives out_a/out_b/switched.
interface signal_switch_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  switch;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic [DATA_WIDTH-1:0] out_a;
   logic [DATA_WIDTH-1:0] out_b;
   logic                  switched;

   modport master (
      output switch,
      output a,
      output b,
      input  out_a,
      input  out_b,
      input  switched
   );

   modport slave (
      input  switch,
      input  a,
      input  b,
      output out_a,
      output out_b,
      output switched
   );
endinterface

// File: rtl/signal_switch.sv
// signal_switch: registered 2x2 crossbar for two signed sample streams.
// sel=0 passes a->out_a, b->out_b; sel=1 swaps them. The swap request is
// asynchronous to SYS_aclk, so it goes through a two-flop synchronizer
// before it reaches sel. Words are copied bit-exact, never partially.
//
// Optional feature: define SIGNAL_SWITCH_BLANK_EN to zero both outputs for
// BLANK_CYCLES cycles starting at the edge where sel changes, so downstream
// logic never sees the transient around a channel swap. Without the macro
// BLANK_CYCLES has no effect.
module signal_switch #(
   parameter int DATA_WIDTH   = 16,
   parameter int BLANK_CYCLES = 4
) (
   input  logic            SYS_aclk,
   input  logic            SYS_aresetn,
   signal_switch_if.slave  bus
);

   // Reject an out-of-range blank length when the design is elaborated
   if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank_cycles
      $error("signal_switch: BLANK_CYCLES must be in 1..255");
   end

   logic                  sync1;
   logic                  sync2;
   logic                  sel;
   logic [DATA_WIDTH-1:0] next_a;
   logic [DATA_WIDTH-1:0] next_b;

   // Two-flop synchronizer bringing the swap request into the SYS_aclk domain
   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= bus.switch;
         sync2 <= sync1;
      end
   end

   // Effective selection; the data mux only ever sees this registered copy
   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         sel <= 1'b0;
      end else begin
         sel <= sync2;
      end
   end

   assign bus.switched = sel;

`ifdef SIGNAL_SWITCH_BLANK_EN
   localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

   logic [7:0] blank_cnt;
   logic       sel_change;
   logic       blank;

   // sel is about to take a new value on this edge; the count of 1 means
   // the final blanked cycle has passed and the new mapping may show
   assign sel_change = (sync2 != sel);
   assign blank      = sel_change || (blank_cnt > 8'd1);

   // Blank counter: reloads on every selection change, otherwise runs down
   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         blank_cnt <= 8'd0;
      end else if (sel_change) begin
         blank_cnt <= BLANK_LOAD;
      end else if (blank_cnt != 8'd0) begin
         blank_cnt <= blank_cnt - 8'd1;
      end
   end

   // Crossbar mux, forced to zero while blanking
   always_comb begin
      next_a = sel ? bus.b : bus.a;
      next_b = sel ? bus.a : bus.b;
      if (blank) begin
         next_a = '0;
         next_b = '0;
      end
   end
`else
   // Crossbar mux: whole words are steered by the registered selection
   always_comb begin
      next_a = sel ? bus.b : bus.a;
      next_b = sel ? bus.a : bus.b;
   end
`endif

   // Output registers: one cycle of data latency
   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         bus.out_a <= '0;
         bus.out_b <= '0;
      end else begin
         bus.out_a <= next_a;
         bus.out_b <= next_b;
      end
   end

endmodule

// File: tb/tb_signal_switch.sv
// Testbench for signal_switch: table of hand-computed vectors for reset,
// pass-through, swap latency and return; an asynchronous mid-stream reset;
// a toggling run checked against a queue of expected words; and, when
// SIGNAL_SWITCH_BLANK_EN is defined, a blank-reload sequence.
module tb_signal_switch;

   localparam int DW    = 16;
   localparam int BLANK = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #4 clk = ~clk;

   signal_switch_if #(.DATA_WIDTH(DW)) bus ();

   signal_switch #(
      .DATA_WIDTH   (DW),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .SYS_aclk    (clk),
      .SYS_aresetn (rst_n),
      .bus         (bus)
   );

   typedef struct {
      logic          sw;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] exp_a;
      logic [DW-1:0] exp_b;
      logic          exp_sw;
   } vec_t;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          sw;
   } exp_t;

   vec_t vecs[11];
   exp_t sb_q[$];
   exp_t exp_now;
   exp_t exp_pop;

   int tests_run    = 0;
   int tests_failed = 0;

   logic m_s1, m_s2, m_sel;
   int   m_cnt;

   task automatic checkOutput(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Drive inputs just after an edge, then sample 1 ns after the next edge
   task automatic applyStimulus(input logic sw, input logic [DW-1:0] a,
                                input logic [DW-1:0] b);
      bus.switch = sw;
      bus.a      = a;
      bus.b      = b;
      @(posedge clk);
      #1;
   endtask

   // Reference model of one rising edge; yields the outputs after that edge
   task automatic modelStep(input logic sw, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, output exp_t e);
      logic blank;
      blank = 1'b0;
`ifdef SIGNAL_SWITCH_BLANK_EN
      blank = (m_s2 != m_sel) || (m_cnt > 1);
`endif
      e.a = blank ? '0 : (m_sel ? b : a);
      e.b = blank ? '0 : (m_sel ? a : b);
`ifdef SIGNAL_SWITCH_BLANK_EN
      if (m_s2 != m_sel) m_cnt = BLANK;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
`endif
      m_sel = m_s2;
      m_s2  = m_s1;
      m_s1  = sw;
      e.sw  = m_sel;
   endtask

   task automatic checkSwitched(input string name, input logic exp);
      checkOutput(name, {{(DW-1){1'b0}}, bus.switched}, {{(DW-1){1'b0}}, exp});
   endtask

   initial begin
      // sw, a, b, expected out_a, out_b, switched (after that row's edge)
      vecs[0]  = '{1'b0, 16'd14,   16'hFFE3, 16'h000E, 16'hFFE3, 1'b0};
      vecs[1]  = '{1'b1, 16'd14,   16'hFFE3, 16'h000E, 16'hFFE3, 1'b0};
      vecs[2]  = '{1'b1, 16'd14,   16'hFFE3, 16'h000E, 16'hFFE3, 1'b0};
      vecs[3]  = '{1'b1, 16'd14,   16'hFFE3, 16'h000E, 16'hFFE3, 1'b1};
      vecs[4]  = '{1'b1, 16'd14,   16'hFFE3, 16'hFFE3, 16'h000E, 1'b1};
      vecs[5]  = '{1'b1, 16'd7,    16'd16,   16'h0010, 16'h0007, 1'b1};
      vecs[6]  = '{1'b0, 16'd7,    16'd16,   16'h0010, 16'h0007, 1'b1};
      vecs[7]  = '{1'b0, 16'd7,    16'd16,   16'h0010, 16'h0007, 1'b1};
      vecs[8]  = '{1'b0, 16'd3,    16'd5,    16'h0005, 16'h0003, 1'b0};
      vecs[9]  = '{1'b0, 16'd7,    16'd16,   16'h0007, 16'h0010, 1'b0};
      vecs[10] = '{1'b0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0};
`ifdef SIGNAL_SWITCH_BLANK_EN
      for (int i = 0; i < 11; i++) begin
         if (i inside {3, 4, 5, 6, 8, 9, 10}) begin
            vecs[i].exp_a = '0;
            vecs[i].exp_b = '0;
         end
      end
`endif

      // Reset held with data present and the clock running
      rst_n      = 1'b0;
      bus.switch = 1'b0;
      bus.a      = 16'd14;
      bus.b      = 16'hFFE3;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset out_a", bus.out_a, 16'h0000);
      checkOutput("reset out_b", bus.out_b, 16'h0000);
      checkSwitched("reset switched", 1'b0);
      rst_n = 1'b1;

      // Table: pass-through, swap latency, data under swap, return
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].sw, vecs[i].a, vecs[i].b);
         checkOutput($sformatf("vec%0d out_a", i), bus.out_a, vecs[i].exp_a);
         checkOutput($sformatf("vec%0d out_b", i), bus.out_b, vecs[i].exp_b);
         checkSwitched($sformatf("vec%0d switched", i), vecs[i].exp_sw);
      end

      // Reset mid-stream, between clock edges
      bus.a = 16'h1234;
      bus.b = 16'h5678;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset out_a", bus.out_a, 16'h0000);
      checkOutput("async reset out_b", bus.out_b, 16'h0000);
      checkSwitched("async reset switched", 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_s1  = 1'b0;
      m_s2  = 1'b0;
      m_sel = 1'b0;
      m_cnt = 0;

      // Toggle switch every 3 cycles with random data, scoreboard-checked
      for (int c = 0; c < 36; c++) begin
         logic          sw;
         logic [DW-1:0] ra;
         logic [DW-1:0] rb;
         sw = ((c / 3) % 2) == 1;
         ra = DW'($urandom);
         rb = DW'($urandom);
         modelStep(sw, ra, rb, exp_now);
         sb_q.push_back(exp_now);
         applyStimulus(sw, ra, rb);
         exp_pop = sb_q.pop_front();
         checkOutput($sformatf("toggle%0d out_a", c), bus.out_a, exp_pop.a);
         checkOutput($sformatf("toggle%0d out_b", c), bus.out_b, exp_pop.b);
         checkSwitched($sformatf("toggle%0d switched", c), exp_pop.sw);
      end

`ifdef SIGNAL_SWITCH_BLANK_EN
      // Re-toggle during blanking: the second change reloads the counter
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 16'd7, 16'd16);
      applyStimulus(1'b0, 16'd7, 16'd16);
      for (int j = 0; j < 10; j++) begin
         logic          zero;
         logic [DW-1:0] ea;
         logic [DW-1:0] eb;
         zero = (j >= 2) && (j <= 8);
         ea   = zero ? 16'h0000 : 16'h0007;
         eb   = zero ? 16'h0000 : 16'h0010;
         applyStimulus(j < 3, 16'd7, 16'd16);
         checkOutput($sformatf("blank%0d out_a", j), bus.out_a, ea);
         checkOutput($sformatf("blank%0d out_b", j), bus.out_b, eb);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
